// File: rtl/arm_exe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : arm_exe_pkg                                                   |
// | Purpose  : Shared encodings for the ARM execute stage: ALU commands,     |
// |            shift types, forward selects, NZCV flag layout and a rotate   |
// |            helper.                                                       |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package arm_exe_pkg;

  // ALU command codes as delivered by ID.
  localparam logic [3:0] c_alu_mov = 4'b0001;
  localparam logic [3:0] c_alu_mvn = 4'b1001;
  localparam logic [3:0] c_alu_add = 4'b0010;
  localparam logic [3:0] c_alu_adc = 4'b0011;
  localparam logic [3:0] c_alu_sub = 4'b0100;
  localparam logic [3:0] c_alu_sbc = 4'b0101;
  localparam logic [3:0] c_alu_and = 4'b0110;
  localparam logic [3:0] c_alu_orr = 4'b0111;
  localparam logic [3:0] c_alu_eor = 4'b1000;

  // Shift type field, shifter_operand[6:5].
  localparam logic [1:0] c_sh_lsl = 2'b00;
  localparam logic [1:0] c_sh_lsr = 2'b01;
  localparam logic [1:0] c_sh_asr = 2'b10;
  localparam logic [1:0] c_sh_ror = 2'b11;

  // Operand forward selects; 2'b11 falls back to the register file value.
  localparam logic [1:0] c_fwd_reg = 2'b00;
  localparam logic [1:0] c_fwd_mem = 2'b01;
  localparam logic [1:0] c_fwd_wb  = 2'b10;

  // Bit positions of the flags inside the 4-bit status word.
  localparam int c_flag_n = 3;
  localparam int c_flag_z = 2;
  localparam int c_flag_c = 1;
  localparam int c_flag_v = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Rotate right; an amount of 0 makes the left shift 32, which yields 0,
  // so the value passes through unchanged.
  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] r);
    logic [5:0] l;
    l = 6'd32 - {1'b0, r};
    return (x >> r) | (x << l);
  endfunction

endpackage
`default_nettype wire

// File: rtl/exe_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: exe_stage_if                                                  |
// | Purpose  : Bundles the ID->EXE inputs, forwarding inputs, IF/ID feedback |
// |            and the EXE->MEM register outputs of the execute stage.       |
// | Modports : master - pipeline side (drives instruction, reads results)    |
// |            slave  - exe_stage side                                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface exe_stage_if;
  // ID->EXE control and data
  logic        freeze;
  logic        status_en;
  logic        mem_read;
  logic        mem_write;
  logic        wb_en;
  logic        branch;
  logic        I;
  logic [31:0] pc;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [3:0]  alu_cmd;
  logic [3:0]  dest;
  logic [23:0] b_signed_imm;
  logic [11:0] shifter_operand;
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] mem_fwd;
  logic [31:0] wb_fwd;
  // Feedback to IF / ID
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status_out;
  // EXE->MEM register
  logic        wb_en_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [31:0] alu_res_out;
  logic [31:0] store_val_out;
  logic [3:0]  dest_out;

  modport master (
    output freeze, status_en, mem_read, mem_write, wb_en, branch, I, pc,
           reg1, reg2, alu_cmd, dest, b_signed_imm, shifter_operand,
           sel_src1, sel_src2, mem_fwd, wb_fwd,
    input  branch_taken, branch_addr, status_out, wb_en_out, mem_read_out,
           mem_write_out, alu_res_out, store_val_out, dest_out
  );

  modport slave (
    input  freeze, status_en, mem_read, mem_write, wb_en, branch, I, pc,
           reg1, reg2, alu_cmd, dest, b_signed_imm, shifter_operand,
           sel_src1, sel_src2, mem_fwd, wb_fwd,
    output branch_taken, branch_addr, status_out, wb_en_out, mem_read_out,
           mem_write_out, alu_res_out, store_val_out, dest_out
  );
endinterface
`default_nettype wire

// File: rtl/exe_val2_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : exe_val2_gen                                                  |
// | Purpose  : Second ALU operand generator (combinational).                 |
// | Ports    : imm_form        in  1   immediate operand form (I bit)        |
// |            mem_access      in  1   LDR/STR: use 12-bit offset            |
// |            shifter_operand in  12  shifter operand / offset field        |
// |            op2             in  32  forwarded Rm                          |
// |            val2            out 32  second operand                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module exe_val2_gen
  import arm_exe_pkg::*;
(
  input  wire logic        imm_form,
  input  wire logic        mem_access,
  input  wire logic [11:0] shifter_operand,
  input  wire logic [31:0] op2,
  output logic [31:0]      val2
);

  logic [4:0]  w_rot_amt;
  logic [4:0]  w_sh_amt;
  logic [31:0] w_shifted;

  // Immediate rotation is by twice the 4-bit rotate field.
  assign w_rot_amt = {shifter_operand[11:8], 1'b0};
  assign w_sh_amt  = shifter_operand[11:7];

  always_comb begin
    w_shifted = op2;
    case (shifter_operand[6:5])
      c_sh_lsl: w_shifted = op2 << w_sh_amt;
      c_sh_lsr: w_shifted = op2 >> w_sh_amt;
      c_sh_asr: w_shifted = $signed(op2) >>> w_sh_amt;
      c_sh_ror: w_shifted = rotr32(op2, w_sh_amt);
      default:  w_shifted = op2;
    endcase
  end

  always_comb begin
    val2 = w_shifted;
    if (imm_form) begin
      val2 = rotr32({24'b0, shifter_operand[7:0]}, w_rot_amt);
    end else if (mem_access) begin
      val2 = {20'b0, shifter_operand};
    end
  end

endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : exe_stage                                                     |
// | Purpose  : ARM execute stage: forwarding muxes, Val2 generator, ALU,     |
// |            branch-target adder, NZCV status register and the registered  |
// |            EXE->MEM boundary.                                            |
// | Ports    : clk  in  1   clock, rising edge                               |
// |            rst  in  1   asynchronous reset, active low                   |
// |            bus  exe_stage_if.slave (instruction in, results out)         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module exe_stage
  import arm_exe_pkg::*;
#(
  parameter int          DW       = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input wire logic   clk,
  input wire logic   rst,
  exe_stage_if.slave bus
);

  logic [DW-1:0] w_op1;
  logic [DW-1:0] w_op2;
  logic [DW-1:0] w_val2;
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_res;
  logic          w_known;
  flags_t        w_flags;
  logic          w_cin;

  flags_t        r_status;
  logic          r_wb_en;
  logic          r_mem_read;
  logic          r_mem_write;
  logic [DW-1:0] r_alu_res;
  logic [DW-1:0] r_store_val;
  logic [3:0]    r_dest;

  // Operand forwarding; the unused select code behaves as the register path.
  always_comb begin
    case (bus.sel_src1)
      c_fwd_mem: w_op1 = bus.mem_fwd;
      c_fwd_wb:  w_op1 = bus.wb_fwd;
      default:   w_op1 = bus.reg1;
    endcase
    case (bus.sel_src2)
      c_fwd_mem: w_op2 = bus.mem_fwd;
      c_fwd_wb:  w_op2 = bus.wb_fwd;
      default:   w_op2 = bus.reg2;
    endcase
  end

  exe_val2_gen u_val2 (
    .imm_form        (bus.I),
    .mem_access      (bus.mem_read | bus.mem_write),
    .shifter_operand (bus.shifter_operand),
    .op2             (w_op2),
    .val2            (w_val2)
  );

  assign w_cin = r_status[c_flag_c];

  // ALU. Subtractions are op1 + ~val2 + carry-in so that the carry out is
  // the ARM "no borrow" flag directly.
  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_flags = '0;
    w_known = 1'b1;
    case (bus.alu_cmd)
      c_alu_mov: w_res = w_val2;
      c_alu_mvn: w_res = ~w_val2;
      c_alu_add, c_alu_adc: begin
        w_sum = {1'b0, w_op1} + {1'b0, w_val2}
              + {{DW{1'b0}}, (bus.alu_cmd == c_alu_adc) & w_cin};
        w_res = w_sum[DW-1:0];
        w_flags.c = w_sum[DW];
        w_flags.v = (w_op1[DW-1] == w_val2[DW-1]) && (w_res[DW-1] != w_op1[DW-1]);
      end
      c_alu_sub, c_alu_sbc: begin
        w_sum = {1'b0, w_op1} + {1'b0, ~w_val2}
              + {{DW{1'b0}}, (bus.alu_cmd == c_alu_sub) | w_cin};
        w_res = w_sum[DW-1:0];
        w_flags.c = w_sum[DW];
        w_flags.v = (w_op1[DW-1] != w_val2[DW-1]) && (w_res[DW-1] != w_op1[DW-1]);
      end
      c_alu_and: w_res = w_op1 & w_val2;
      c_alu_orr: w_res = w_op1 | w_val2;
      c_alu_eor: w_res = w_op1 ^ w_val2;
      default:   w_known = 1'b0;
    endcase
    // Undefined commands report all flags clear, including Z.
    if (w_known) begin
      w_flags.n = w_res[DW-1];
      w_flags.z = (w_res == '0);
    end
  end

  // Status register: no bypass, ID sees new flags one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status <= '0;
    end else if (bus.status_en && !bus.freeze) begin
      r_status <= w_flags;
    end
  end

  // EXE->MEM pipeline register; freeze holds every field.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_en     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_alu_res   <= RESET_PC;
      r_store_val <= '0;
      r_dest      <= '0;
    end else if (!bus.freeze) begin
      r_wb_en     <= bus.wb_en;
      r_mem_read  <= bus.mem_read;
      r_mem_write <= bus.mem_write;
      r_alu_res   <= w_res;
      r_store_val <= w_op2;
      r_dest      <= bus.dest;
    end
  end

  // Branch offset is in words and signed from bit 23; the add wraps.
  assign bus.branch_taken  = bus.branch;
  assign bus.branch_addr   = bus.pc + {{6{bus.b_signed_imm[23]}}, bus.b_signed_imm, 2'b00};
  assign bus.status_out    = r_status;
  assign bus.wb_en_out     = r_wb_en;
  assign bus.mem_read_out  = r_mem_read;
  assign bus.mem_write_out = r_mem_write;
  assign bus.alu_res_out   = r_alu_res;
  assign bus.store_val_out = r_store_val;
  assign bus.dest_out      = r_dest;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_exe_stage                                                  |
// | Purpose  : Directed self-checking bench for exe_stage.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_exe_stage;
  import arm_exe_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  exe_stage_if bus ();

  exe_stage #(
    .DW       (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.freeze = 0; bus.status_en = 0; bus.mem_read = 0; bus.mem_write = 0;
    bus.wb_en = 0; bus.branch = 0; bus.I = 0; bus.pc = 0; bus.reg1 = 0;
    bus.reg2 = 0; bus.alu_cmd = 0; bus.dest = 0; bus.b_signed_imm = 0;
    bus.shifter_operand = 0; bus.sel_src1 = 0; bus.sel_src2 = 0;
    bus.mem_fwd = 0; bus.wb_fwd = 0;
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic imm, input logic [11:0] so,
                        input logic [31:0] r1, input logic [31:0] r2, input logic sten);
    bus.alu_cmd = cmd; bus.I = imm; bus.shifter_operand = so;
    bus.reg1 = r1; bus.reg2 = r2; bus.status_en = sten;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.status_out !== 4'b0000) begin n_bad++; $display("FAIL reset_status: got %b want 0000", bus.status_out); end
    n_cmp++; if (bus.alu_res_out !== 32'h0) begin n_bad++; $display("FAIL reset_res: got %h want 0", bus.alu_res_out); end
    n_cmp++; if ({bus.wb_en_out, bus.mem_read_out, bus.mem_write_out} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl: got %b want 000", {bus.wb_en_out, bus.mem_read_out, bus.mem_write_out}); end
    n_cmp++; if (bus.store_val_out !== 32'h0 || bus.dest_out !== 4'h0) begin n_bad++; $display("FAIL reset_store_dest: got %h/%h want 0/0", bus.store_val_out, bus.dest_out); end
    rst = 1'b1;
  endtask

  task automatic test_add_flags();
    clear_inputs();
    set_op(c_alu_add, 1, 12'h001, 32'h7FFFFFFF, 0, 1);
    bus.wb_en = 1; bus.dest = 4'd3;
    step();
    n_cmp++; if (bus.alu_res_out !== 32'h80000000) begin n_bad++; $display("FAIL add_res: got %h want 80000000", bus.alu_res_out); end
    n_cmp++; if (bus.status_out !== 4'b1001) begin n_bad++; $display("FAIL add_flags: got %b want 1001", bus.status_out); end
    n_cmp++; if (bus.dest_out !== 4'd3 || bus.wb_en_out !== 1'b1) begin n_bad++; $display("FAIL add_ctrl: got %h/%b want 3/1", bus.dest_out, bus.wb_en_out); end
  endtask

  task automatic test_sub_sbc();
    clear_inputs();
    set_op(c_alu_sub, 1, 12'h005, 32'd5, 0, 1);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'h0) begin n_bad++; $display("FAIL sub_res: got %h want 0", bus.alu_res_out); end
    n_cmp++; if (bus.status_out !== 4'b0110) begin n_bad++; $display("FAIL sub_flags: got %b want 0110", bus.status_out); end
    set_op(c_alu_sbc, 1, 12'h003, 32'd5, 0, 0);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'd2) begin n_bad++; $display("FAIL sbc_res: got %h want 2", bus.alu_res_out); end
    set_op(c_alu_adc, 1, 12'h001, 32'd1, 0, 0);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'd3) begin n_bad++; $display("FAIL adc_res: got %h want 3", bus.alu_res_out); end
    n_cmp++; if (bus.status_out !== 4'b0110) begin n_bad++; $display("FAIL sr_hold: got %b want 0110", bus.status_out); end
    set_op(4'b0000, 1, 12'h0FF, 32'd7, 0, 1);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'h0 || bus.status_out !== 4'b0000) begin n_bad++; $display("FAIL bad_cmd: got %h/%b want 0/0000", bus.alu_res_out, bus.status_out); end
  endtask

  task automatic test_val2_logic();
    clear_inputs();
    set_op(c_alu_mov, 1, 12'h2FF, 0, 0, 0);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'hF000000F) begin n_bad++; $display("FAIL mov_rot: got %h want F000000F", bus.alu_res_out); end
    set_op(c_alu_mov, 0, 12'h200, 0, 32'h1, 0);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'h10) begin n_bad++; $display("FAIL lsl4: got %h want 10", bus.alu_res_out); end
    set_op(c_alu_mov, 0, 12'h0C0, 0, 32'h80000000, 0);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'hC0000000) begin n_bad++; $display("FAIL asr1: got %h want C0000000", bus.alu_res_out); end
    set_op(c_alu_mov, 0, 12'h0A0, 0, 32'h80000000, 0);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'h40000000) begin n_bad++; $display("FAIL lsr1: got %h want 40000000", bus.alu_res_out); end
    set_op(c_alu_mov, 0, 12'h260, 0, 32'h12345678, 0);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'h81234567) begin n_bad++; $display("FAIL ror4: got %h want 81234567", bus.alu_res_out); end
    set_op(c_alu_mov, 0, 12'h060, 0, 32'hDEADBEEF, 0);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'hDEADBEEF) begin n_bad++; $display("FAIL shift0: got %h want DEADBEEF", bus.alu_res_out); end
    set_op(c_alu_mvn, 1, 12'h000, 0, 0, 0);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mvn: got %h want FFFFFFFF", bus.alu_res_out); end
    set_op(c_alu_and, 1, 12'h00F, 32'hF0, 0, 1);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'h0 || bus.status_out !== 4'b0100) begin n_bad++; $display("FAIL and: got %h/%b want 0/0100", bus.alu_res_out, bus.status_out); end
    set_op(c_alu_orr, 1, 12'h00F, 32'hF0, 0, 0);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'hFF) begin n_bad++; $display("FAIL orr: got %h want FF", bus.alu_res_out); end
    set_op(c_alu_eor, 1, 12'h00F, 32'hFF, 0, 0);
    step();
    n_cmp++; if (bus.alu_res_out !== 32'hF0) begin n_bad++; $display("FAIL eor: got %h want F0", bus.alu_res_out); end
  endtask

  task automatic test_forward();
    clear_inputs();
    set_op(c_alu_add, 1, 12'h001, 32'h0, 0, 0);
    bus.sel_src1 = 2'b01; bus.mem_fwd = 32'd100;
    step();
    n_cmp++; if (bus.alu_res_out !== 32'd101) begin n_bad++; $display("FAIL fwd_mem: got %0d want 101", bus.alu_res_out); end
    clear_inputs();
    set_op(c_alu_add, 0, 12'hABC, 32'h1000, 32'd7, 0);
    bus.mem_write = 1; bus.sel_src2 = 2'b10; bus.wb_fwd = 32'd9;
    step();
    n_cmp++; if (bus.store_val_out !== 32'd9) begin n_bad++; $display("FAIL fwd_wb_store: got %0d want 9", bus.store_val_out); end
    n_cmp++; if (bus.alu_res_out !== 32'h1ABC || bus.mem_write_out !== 1'b1) begin n_bad++; $display("FAIL str_addr: got %h/%b want 1ABC/1", bus.alu_res_out, bus.mem_write_out); end
    clear_inputs();
    set_op(c_alu_add, 1, 12'h000, 32'd20, 0, 0);
    bus.sel_src1 = 2'b11; bus.mem_fwd = 32'd999; bus.wb_fwd = 32'd555;
    step();
    n_cmp++; if (bus.alu_res_out !== 32'd20) begin n_bad++; $display("FAIL sel11: got %0d want 20", bus.alu_res_out); end
  endtask

  task automatic test_freeze();
    clear_inputs();
    set_op(c_alu_mov, 1, 12'h042, 0, 0, 1);
    bus.wb_en = 1; bus.dest = 4'd7;
    step();
    set_op(c_alu_sub, 1, 12'h005, 32'd5, 0, 1);
    bus.wb_en = 0; bus.mem_read = 1; bus.dest = 4'd9; bus.freeze = 1;
    for (int i = 0; i < 3; i++) begin
      bus.reg1 = 32'd5 + 32'(i) * 0; bus.reg2 = 32'(i + 11);
      step();
      n_cmp++; if (bus.alu_res_out !== 32'h42 || bus.status_out !== 4'b0000) begin n_bad++; $display("FAIL freeze_res_sr: got %h/%b want 42/0000", bus.alu_res_out, bus.status_out); end
      n_cmp++; if (bus.dest_out !== 4'd7 || bus.wb_en_out !== 1'b1 || bus.mem_read_out !== 1'b0) begin n_bad++; $display("FAIL freeze_ctrl: got %h/%b/%b want 7/1/0", bus.dest_out, bus.wb_en_out, bus.mem_read_out); end
    end
    bus.freeze = 0;
    step();
    n_cmp++; if (bus.alu_res_out !== 32'h0 || bus.status_out !== 4'b0110) begin n_bad++; $display("FAIL unfreeze: got %h/%b want 0/0110", bus.alu_res_out, bus.status_out); end
    n_cmp++; if (bus.dest_out !== 4'd9 || bus.mem_read_out !== 1'b1) begin n_bad++; $display("FAIL unfreeze_ctrl: got %h/%b want 9/1", bus.dest_out, bus.mem_read_out); end
  endtask

  task automatic test_branch_reset();
    clear_inputs();
    bus.branch = 1; bus.pc = 32'h100; bus.b_signed_imm = 24'hFFFFFE;
    #1;
    n_cmp++; if (bus.branch_taken !== 1'b1 || bus.branch_addr !== 32'h0F8) begin n_bad++; $display("FAIL br_neg: got %b/%h want 1/000000F8", bus.branch_taken, bus.branch_addr); end
    bus.b_signed_imm = 24'h000010;
    #1;
    n_cmp++; if (bus.branch_addr !== 32'h140) begin n_bad++; $display("FAIL br_pos: got %h want 00000140", bus.branch_addr); end
    bus.pc = 32'hFFFFFFFC; bus.b_signed_imm = 24'h000001;
    #1;
    n_cmp++; if (bus.branch_addr !== 32'h0) begin n_bad++; $display("FAIL br_wrap: got %h want 0", bus.branch_addr); end
    bus.branch = 0;
    #1;
    n_cmp++; if (bus.branch_taken !== 1'b0) begin n_bad++; $display("FAIL br_not: got %b want 0", bus.branch_taken); end
    set_op(c_alu_sub, 1, 12'h001, 32'd0, 0, 1);
    bus.wb_en = 1; bus.dest = 4'd5; bus.mem_write = 1;
    step();
    bus.freeze = 1;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.alu_res_out !== 32'h0 || bus.status_out !== 4'b0000) begin n_bad++; $display("FAIL rst_async: got %h/%b want 0/0000", bus.alu_res_out, bus.status_out); end
    n_cmp++; if ({bus.wb_en_out, bus.mem_write_out} !== 2'b00 || bus.dest_out !== 4'd0) begin n_bad++; $display("FAIL rst_async_ctrl: got %b/%h want 00/0", {bus.wb_en_out, bus.mem_write_out}, bus.dest_out); end
    #3;
    rst = 1'b1;
    bus.freeze = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    test_reset();
    test_add_flags();
    test_sub_sbc();
    test_val2_logic();
    test_forward();
    test_freeze();
    test_branch_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
